// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM fader and its helpers.
package pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RISE      = 3'd1,
        ST_HOLD_HIGH = 3'd2,
        ST_FALL      = 3'd3,
        ST_HOLD_LOW  = 3'd4
    } state_e;

    // Full-scale duty value (100%) for a given counter resolution.
    function automatic int unsigned full_scale(input int unsigned resolution);
        return 32'd1 << resolution;
    endfunction

endpackage

// File: rtl/pwm_cycle_prescaler.sv
// Counts PWM cycle-end ticks and flags the tick on which the count reaches the limit.
module pwm_cycle_prescaler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_match_c
);

    logic [WIDTH-1:0] count;

    assign o_match_c = i_tick && (count == i_limit);

    // Equality compare only: a limit lowered below the count wraps through zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_clear || o_match_c) begin
            count <= '0;
        end else if (i_tick) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_fader.sv
// Breathing-envelope driver: rewrites the PWM generator's compare value in a
// rise/hold/fall/hold triangle, paced by the generator's cycle-end pulse.
module pwm_fader
    import pwm_pkg::*;
#(
    parameter int unsigned RESOLUTION     = 8,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_cycle_end,
    input  logic [RESOLUTION-1:0]     i_step,
    input  logic [PRESCALE_WIDTH-1:0] i_cycles_per_step,
    input  logic [PRESCALE_WIDTH-1:0] i_hold_cycles,
    output logic [RESOLUTION-1:0]     o_top,
    output logic                      o_top_valid,
    output logic [RESOLUTION:0]       o_compare,
    output logic                      o_compare_valid,
    output logic [2:0]                o_state
);

    localparam int unsigned SUM_W = RESOLUTION + 2;
    localparam logic [SUM_W-1:0]    FULL_SUM = SUM_W'(full_scale(RESOLUTION));
    localparam logic [RESOLUTION:0] FULL_CMP = (RESOLUTION + 1)'(full_scale(RESOLUTION));

    state_e             state;
    logic               top_fired;
    logic               ramping_c;
    logic               holding_c;
    logic               disable_c;
    logic               step_match_c;
    logic               hold_match_c;
    logic [SUM_W-1:0]   rise_sum_c;
    logic [RESOLUTION:0] step_ext_c;

    assign o_top   = '1;
    assign o_state = state;

    assign ramping_c  = (state == ST_RISE) || (state == ST_FALL);
    assign holding_c  = (state == ST_HOLD_HIGH) || (state == ST_HOLD_LOW);
    assign disable_c  = !i_enable && (state != ST_IDLE);
    assign rise_sum_c = SUM_W'(o_compare) + SUM_W'(i_step);
    assign step_ext_c = (RESOLUTION + 1)'(i_step);

    // Each counter is held clear outside the states that use it, so every entry starts at zero.
    pwm_cycle_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_step_prescaler (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (!ramping_c || disable_c),
        .i_tick    (i_cycle_end && ramping_c && i_enable),
        .i_limit   (i_cycles_per_step),
        .o_match_c (step_match_c)
    );

    pwm_cycle_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_hold_prescaler (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (!holding_c || disable_c),
        .i_tick    (i_cycle_end && holding_c && i_enable),
        .i_limit   (i_hold_cycles),
        .o_match_c (hold_match_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            o_compare       <= '0;
            o_compare_valid <= 1'b0;
            o_top_valid     <= 1'b0;
            top_fired       <= 1'b0;
        end else begin
            o_compare_valid <= 1'b0;
            o_top_valid     <= !top_fired;
            top_fired       <= 1'b1;

            // Disable parks at 0% immediately and outranks a coincident cycle end.
            if (disable_c) begin
                state           <= ST_IDLE;
                o_compare       <= '0;
                o_compare_valid <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_enable) state <= ST_RISE;
                    end
                    ST_RISE: begin
                        if (step_match_c) begin
                            o_compare_valid <= 1'b1;
                            if (rise_sum_c >= FULL_SUM) begin
                                o_compare <= FULL_CMP;
                                state     <= ST_HOLD_HIGH;
                            end else begin
                                o_compare <= rise_sum_c[RESOLUTION:0];
                            end
                        end
                    end
                    ST_FALL: begin
                        if (step_match_c) begin
                            o_compare_valid <= 1'b1;
                            if (o_compare <= step_ext_c) begin
                                o_compare <= '0;
                                state     <= ST_HOLD_LOW;
                            end else begin
                                o_compare <= o_compare - step_ext_c;
                            end
                        end
                    end
                    ST_HOLD_HIGH: begin
                        if (hold_match_c) state <= ST_FALL;
                    end
                    ST_HOLD_LOW: begin
                        if (hold_match_c) state <= ST_RISE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Scoreboard bench for pwm_fader at RESOLUTION=4, PRESCALE_WIDTH=4, cycle end every 17 clocks.
module tb_pwm_fader;

    localparam int unsigned RES = 4;
    localparam int unsigned PW  = 4;
    localparam int unsigned FULL = 16;
    localparam int unsigned S_IDLE = 0, S_RISE = 1, S_HH = 2, S_FALL = 3, S_HL = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           cycle_end = 1'b0;
    logic [RES-1:0] step = '0;
    logic [PW-1:0]  cycles_per_step = '0;
    logic [PW-1:0]  hold_cycles = '0;
    logic [RES-1:0] top;
    logic           top_valid;
    logic [RES:0]   compare;
    logic           compare_valid;
    logic [2:0]     state;

    int unsigned exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    pwm_fader #(.RESOLUTION(RES), .PRESCALE_WIDTH(PW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (enable),
        .i_cycle_end      (cycle_end),
        .i_step           (step),
        .i_cycles_per_step(cycles_per_step),
        .i_hold_cycles    (hold_cycles),
        .o_top            (top),
        .o_top_valid      (top_valid),
        .o_compare        (compare),
        .o_compare_valid  (compare_valid),
        .o_state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Every valid pulse must match the oldest pending expectation; one-clock pulses pop once.
    always @(negedge clk) begin
        if (!rst && compare_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                check("sb_compare", compare, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PWM period: cycle_end for one clock, then 16 quiet clocks.
    task automatic ce(input bit exp_valid, input int unsigned exp_cmp, input int unsigned exp_state);
        cycle_end = 1'b1;
        if (exp_valid) exp_q.push_back(exp_cmp);
        tick();
        cycle_end = 1'b0;
        check("ce_valid", compare_valid, exp_valid);
        check("ce_compare", compare, exp_cmp);
        check("ce_state", state, exp_state);
        repeat (16) tick();
    endtask

    task automatic do_disable(input bit with_ce);
        enable = 1'b0;
        cycle_end = with_ce;
        exp_q.push_back(0);
        tick();
        cycle_end = 1'b0;
        check("dis_valid", compare_valid, 1);
        check("dis_compare", compare, 0);
        check("dis_state", state, S_IDLE);
        tick();
        check("dis_valid_width", compare_valid, 0);
        repeat (15) tick();
    endtask

    task automatic do_enable(input int unsigned exp_cmp);
        enable = 1'b1;
        tick();
        check("en_state", state, S_RISE);
        check("en_valid", compare_valid, 0);
        check("en_compare", compare, exp_cmp);
        repeat (16) tick();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        tick();
        check("top_valid_first", top_valid, 1);
        tick();
        check("top_valid_once", top_valid, 0);
        repeat (3) tick();
        check("top_valid_stays", top_valid, 0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_compare", compare, 0);
        check("rst_state", state, S_IDLE);
        check("rst_valid", compare_valid, 0);
        check("rst_top_valid", top_valid, 0);
        check("top_const", top, FULL - 1);
        release_reset();

        // Basic triangle: step 4, N=0, H=0
        step = 4'd4;
        do_enable(0);
        ce(1, 4, S_RISE); ce(1, 8, S_RISE); ce(1, 12, S_RISE); ce(1, 16, S_HH);
        ce(0, 16, S_FALL);
        ce(1, 12, S_FALL); ce(1, 8, S_FALL); ce(1, 4, S_FALL); ce(1, 0, S_HL);
        ce(0, 0, S_RISE);
        ce(1, 4, S_RISE);

        // Saturating ramps with step 5
        do_disable(0);
        step = 4'd5;
        do_enable(0);
        ce(1, 5, S_RISE); ce(1, 10, S_RISE); ce(1, 15, S_RISE); ce(1, 16, S_HH);
        ce(0, 16, S_FALL);
        ce(1, 11, S_FALL); ce(1, 6, S_FALL); ce(1, 1, S_FALL); ce(1, 0, S_HL);
        ce(0, 0, S_RISE);

        // Prescale N=2: a step every third cycle end
        cycles_per_step = 4'd2;
        ce(0, 0, S_RISE); ce(0, 0, S_RISE); ce(1, 5, S_RISE);
        ce(0, 5, S_RISE); ce(0, 5, S_RISE); ce(1, 10, S_RISE);

        // Hold H=3: four cycle ends in HOLD_HIGH
        cycles_per_step = 4'd0;
        hold_cycles = 4'd3;
        step = 4'd6;
        ce(1, 16, S_HH);
        ce(0, 16, S_HH); ce(0, 16, S_HH); ce(0, 16, S_HH);
        ce(0, 16, S_FALL);
        ce(1, 10, S_FALL);

        hold_cycles = 4'd0;
        step = 4'd4;
        ce(1, 6, S_FALL); ce(1, 2, S_FALL); ce(1, 0, S_HL);
        ce(0, 0, S_RISE);
        ce(1, 4, S_RISE); ce(1, 8, S_RISE);

        // Zero step freezes the ramp but still pulses valid
        step = 4'd0;
        ce(1, 8, S_RISE);
        step = 4'd4;

        // Disable mid-rise at 8, idle stays quiet, re-enable restarts from 0
        do_disable(0);
        ce(0, 0, S_IDLE); ce(0, 0, S_IDLE);
        do_enable(0);
        ce(1, 4, S_RISE); ce(1, 8, S_RISE);

        // Disable coincident with cycle end: disable wins
        do_disable(1);

        // Async reset mid-fall
        step = 4'd8;
        do_enable(0);
        ce(1, 8, S_RISE); ce(1, 16, S_HH); ce(0, 16, S_FALL); ce(1, 8, S_FALL);
        #3;
        rst = 1'b1;
        #1;
        check("arst_compare", compare, 0);
        check("arst_state", state, S_IDLE);
        check("arst_valid", compare_valid, 0);
        check("arst_top_valid", top_valid, 0);
        enable = 1'b0;
        tick();
        release_reset();
        ce(0, 0, S_IDLE);
        do_enable(0);
        ce(1, 8, S_RISE);

        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
- Upstream companion to the PWM generator: produces a "breathing" duty-cycle ramp by rewriting the generator's compare value once per programmable number of PWM cycles.
- Paced entirely by the generator's cycle-end pulse, so compare updates are always ready before the generator's next latch point.
- Runs a rise/hold/fall/hold triangle envelope with saturating arithmetic, so 0% and 100% are reached exactly.

Parameters:
- RESOLUTION, 8, PWM counter width; must match the downstream generator.
- PRESCALE_WIDTH, 8, width of the cycles-per-step and hold counters.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  level; high runs the envelope, low parks output at 0%.
- i_cycle_end  in  1  one-cycle pulse from the generator at each PWM period wrap.
- i_step  in  RESOLUTION  compare increment/decrement per step.
- i_cycles_per_step  in  PRESCALE_WIDTH  N; a step occurs every N+1 cycle-end pulses.
- i_hold_cycles  in  PRESCALE_WIDTH  H; dwell of H+1 cycle-end pulses at each extreme.
- o_top  out  RESOLUTION  constant all-ones (full-resolution period).
- o_top_valid  out  1  single pulse on the first clock after reset deasserts.
- o_compare  out  RESOLUTION+1  duty value, 0..FULL where FULL = 2^RESOLUTION.
- o_compare_valid  out  1  one-cycle pulse whenever o_compare changes or is re-forced.
- o_state  out  3  current envelope state encoding (debug).

Behaviour:
- Reset values: o_compare=0, o_compare_valid=0, o_top_valid=0, state=IDLE, prescale counter=0, hold counter=0. o_top is a constant.
- o_top_valid: a one-shot flag fires on the first clock after i_rst falls. It does not fire again until the next reset.
- All other outputs are registered. o_compare_valid asserts on the clock after the qualifying i_cycle_end, and o_compare holds its new value from that same clock.
- States: IDLE, RISE, HOLD_HIGH, FALL, HOLD_LOW.
- IDLE:
  - When i_enable=1, go to RISE with the prescale counter cleared.
  - o_compare is not changed on this entry.
- Step event: an i_cycle_end with prescale counter == i_cycles_per_step. On a step event the counter clears; otherwise each i_cycle_end increments it.
  - Step events only occur in RISE and FALL.
- RISE step:
  - next = o_compare + i_step, computed in RESOLUTION+2 bits.
  - If next >= FULL: o_compare=FULL, go to HOLD_HIGH, clear the hold counter.
  - Otherwise o_compare=next.
- FALL step:
  - If o_compare <= i_step: o_compare=0, go to HOLD_LOW, clear the hold counter.
  - Otherwise o_compare -= i_step.
- HOLD_HIGH / HOLD_LOW:
  - Count i_cycle_end pulses. When the hold counter == i_hold_cycles on an i_cycle_end, go to FALL or RISE respectively.
  - Clear the prescale counter on exit. No compare change and no valid pulse in hold states.
- i_step == 0:
  - In RISE/FALL, step events still pulse o_compare_valid, but the value is unchanged and there is no state transition (frozen ramp).
  - Exception: if o_compare already sits at the boundary, the saturation rules above apply (0 in FALL goes to HOLD_LOW).
- i_enable falls in any non-IDLE state:
  - Next clock: state=IDLE, o_compare=0, one o_compare_valid pulse, counters cleared.
  - This does not wait for i_cycle_end; the generator applies it at its own next wrap.
- i_enable low while IDLE: no further valid pulses.
- Configuration inputs are sampled live at each comparison. A change mid-ramp takes effect at the next step or hold comparison.
- i_cycle_end in the same clock as i_enable falling: the disable wins.
- Counter wrap: counters compare for equality, so they never exceed the configured value. If the configured value is lowered below the current count, the counter wraps through 2^PRESCALE_WIDTH before matching; this is accepted.
- Reset asserted mid-ramp: immediate return to the reset values. The generator sees compare 0 only after the next valid pulse, which is none until a step or disable occurs.

Decomposition:
- Shared package pwm_pkg: state enum (IDLE=0, RISE=1, HOLD_HIGH=2, FALL=3, HOLD_LOW=4) and a FULL-scale constant function of RESOLUTION.
- One natural sub-module, pwm_cycle_prescaler: counts i_cycle_end against a limit, with clear and match outputs. Instantiated twice, once for step pacing and once for hold.

Test Plan (RESOLUTION=4, FULL=16, PRESCALE_WIDTH=4, cycle_end pulsed every 17 clocks):
- Reset then enable, step=4, N=0, H=0:
  - Compare sequence 4, 8, 12, 16 on successive cycle_ends.
  - One cycle_end of HOLD_HIGH, then 12, 8, 4, 0, then HOLD_LOW, then 4 again.
  - o_top_valid pulses once after reset.
- step=5, rising: sequence 5, 10, 15, 16 (saturates) and goes to HOLD_HIGH. Falling: 11, 6, 1, 0, then HOLD_LOW.
- N=2: compare changes only on every third cycle_end. Valid pulses are exactly one clock wide, one clock after the cycle_end.
- H=3: exactly 4 cycle_end pulses elapse in HOLD_HIGH with no valid pulse before the first FALL step.
- Disable mid-RISE at compare=8: next clock compare=0 with a valid pulse and state IDLE. Re-enable: restart 4, 8, … from 0.
- Assert i_rst asynchronously mid-FALL, between clock edges: outputs zero immediately. No valid pulse until re-enabled and the first step occurs.
